// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART receiver definitions: receiver state encoding and the default
// oversampling ratio.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default number of sample_tick pulses per bit period.
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Receiver frame-sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/rx_rdr.sv
// -----------------------------------------------------------------------------
// rdr -- receive data register for the UART receiver.
// Holds the last delivered word, the rx_valid/rx_ack handshake and the sticky
// error flags.
// Optional feature macro: RX_PARITY_EN (parity_err register present when
// defined, otherwise parity_err is tied to 0).
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   i_done       in   one-clk pulse: a frame has just completed
//   i_word       in   received data word of the completed frame
//   i_stop_bad   in   stop bit of the completed frame was sampled low
//   i_par_bad    in   parity check of the completed frame failed
//   rx_ack       in   consumer acknowledge pulse
//   d_o          out  last delivered word
//   rx_valid     out  d_o holds unacknowledged data
//   framing_err  out  sticky framing error
//   overrun_err  out  sticky overrun error
//   parity_err   out  sticky parity error
// -----------------------------------------------------------------------------
module rdr #(
  parameter int unsigned DATA_SIZE = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_done,
  input  logic [DATA_SIZE-1:0] i_word,
  input  logic                 i_stop_bad,
  input  logic                 i_par_bad,
  input  logic                 rx_ack,
  output logic [DATA_SIZE-1:0] d_o,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  logic [DATA_SIZE-1:0] r_d;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_oerr;

  logic                 w_load;
  logic                 w_overrun;
  logic                 w_clear;

  // A coincident ack frees the register, so the new word is accepted.
  assign w_load    = i_done & (~r_valid | rx_ack);
  assign w_overrun = i_done & r_valid & ~rx_ack;
  assign w_clear   = ~i_done & rx_ack & r_valid;

  // Data register, handshake and framing/overrun flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d     <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else if (w_load) begin
      r_d     <= i_word;
      r_valid <= 1'b1;
      r_ferr  <= i_stop_bad;
      r_oerr  <= 1'b0;
    end else if (w_overrun) begin
      // New word is dropped; its framing status still accumulates.
      r_oerr  <= 1'b1;
      r_ferr  <= r_ferr | i_stop_bad;
    end else if (w_clear) begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  logic r_perr;

  // Parity flag follows the same load/overrun/clear rules as framing_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= i_par_bad;
    end else if (w_overrun) begin
      r_perr <= r_perr | i_par_bad;
    end else if (w_clear) begin
      r_perr <= 1'b0;
    end
  end

  assign parity_err = r_perr;
`else
  logic w_unused_par;

  assign w_unused_par = i_par_bad;
  assign parity_err   = 1'b0;
`endif

  assign d_o         = r_d;
  assign rx_valid    = r_valid;
  assign framing_err = r_ferr;
  assign overrun_err = r_oerr;

endmodule : rdr

// File: rtl/rx.sv
// -----------------------------------------------------------------------------
// rx -- oversampling UART receiver.
// Synchronizes the serial line, finds the start bit, samples data bits LSB
// first at mid-bit, checks the stop bit and hands the frame to the rdr output
// register one clk after the stop sample.
// Optional feature macro: RX_PARITY_EN (one even-parity bit after the data).
// OVERSAMPLE must be even and at least 4.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   sample_tick  in   one-clk pulse at OVERSAMPLE x baud rate
//   data_in      in   serial line, idle high, asynchronous to clk
//   rx_ack       in   consumer acknowledge pulse for d_o
//   d_o          out  last received word
//   rx_valid     out  d_o holds unacknowledged data
//   framing_err  out  sticky: a stop bit was sampled low
//   overrun_err  out  sticky: a frame completed while rx_valid was 1
//   parity_err   out  sticky: parity mismatch (0 without RX_PARITY_EN)
// -----------------------------------------------------------------------------
module rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 7,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 data_in,
  input  logic                 rx_ack,
  output logic [DATA_SIZE-1:0] d_o,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_SIZE + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_line_d;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_done;
  logic                 r_stop_bad;

  logic                 w_line;
  logic                 w_fall;
  logic                 w_half_hit;
  logic                 w_full_hit;
  logic                 w_last_bit;
  logic                 w_par_bad;

  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_done;
`ifdef RX_PARITY_EN
  logic                 w_par_en;
  logic                 r_par_bad;
`endif

  // Two-flop line synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync1  <= data_in;
      r_sync2  <= r_sync1;
      r_line_d <= r_sync2;
    end
  end

  assign w_line     = r_sync2;
  assign w_fall     = r_line_d & ~r_sync2;
  assign w_half_hit = sample_tick & (r_cnt == HALF_LAST);
  assign w_full_hit = sample_tick & (r_cnt == FULL_LAST);
  assign w_last_bit = (r_bit_cnt == BIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A line back high at mid start bit is a glitch, not a frame.
        if (w_half_hit) begin
          w_state_nxt = w_line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_full_hit && w_last_bit) begin
`ifdef RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (w_full_hit) begin
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_full_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath control strobes; counters only move on sample_tick.
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_bit_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
`ifdef RX_PARITY_EN
    w_par_en   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Held clear so counting starts from zero at the falling edge.
        w_cnt_clr = 1'b1;
        w_bit_clr = 1'b1;
      end
      ST_START: begin
        if (w_half_hit) begin
          w_cnt_clr = 1'b1;
        end else if (sample_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_full_hit) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
        end else if (sample_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (w_full_hit) begin
          w_cnt_clr = 1'b1;
          w_par_en  = 1'b1;
        end else if (sample_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_full_hit) begin
          w_cnt_clr = 1'b1;
          w_done    = 1'b1;
        end else if (sample_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_bit_clr = 1'b1;
      end
    endcase
  end

  // Sample/bit counters, shift register and frame-complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end

      // LSB arrives first, so shift in from the top.
      if (w_shift_en) begin
        r_shift <= {w_line, r_shift[DATA_SIZE-1:1]};
      end

      r_done <= w_done;
      if (w_done) begin
        r_stop_bad <= ~w_line;
      end
    end
  end

`ifdef RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_bad <= 1'b0;
    end else if (w_par_en) begin
      r_par_bad <= (^r_shift) ^ w_line;
    end
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // r_shift is stable through the cycle after r_done, so it feeds rdr directly.
  rdr #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rdr (
    .clk         (clk),
    .reset       (reset),
    .i_done      (r_done),
    .i_word      (r_shift),
    .i_stop_bad  (r_stop_bad),
    .i_par_bad   (w_par_bad),
    .rx_ack      (rx_ack),
    .d_o         (d_o),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

endmodule : rx

// File: tb/tb_rx.sv
// -----------------------------------------------------------------------------
// tb_rx -- scoreboard bench for the rx UART receiver.
// Stimulus drives serial frames with a randomly gapped sample_tick and pushes
// the expected visible output state; a monitor pops an entry each time the
// DUT outputs change and compares.
// -----------------------------------------------------------------------------
module tb_rx;

  localparam int unsigned DS = 7;
  localparam int unsigned OS = 16;
`ifdef RX_PARITY_EN
  localparam int unsigned EXTRA  = 1;
  localparam bit          PAR_EN = 1'b1;
`else
  localparam int unsigned EXTRA  = 0;
  localparam bit          PAR_EN = 1'b0;
`endif
  // Ticks from the first DUT START-state cycle to the stop sample.
  localparam int unsigned STOP_TARGET = OS / 2 + OS * (DS + EXTRA) + OS;

  typedef struct packed {
    logic [DS-1:0] d;
    logic          v;
    logic          fe;
    logic          oe;
    logic          pe;
  } obs_t;

  logic          clk;
  logic          reset;
  logic          sample_tick;
  logic          data_in;
  logic          rx_ack;
  logic [DS-1:0] d_o;
  logic          rx_valid;
  logic          framing_err;
  logic          overrun_err;
  logic          parity_err;

  obs_t model;
  obs_t exp_q[$];
  int   total;
  int   bad;
  bit   mon_on;

  rx #(
    .DATA_SIZE  (DS),
    .OVERSAMPLE (OS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .data_in     (data_in),
    .rx_ack      (rx_ack),
    .d_o         (d_o),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Randomly gapped sample ticks.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t sample_dut();
    obs_t s;
    s = {d_o, rx_valid, framing_err, overrun_err, parity_err};
    return s;
  endfunction

  function automatic obs_t mk(logic [DS-1:0] d, logic v, logic fe, logic oe, logic pe);
    obs_t s;
    s = {d, v, fe, oe, pe};
    return s;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got d_o=%h v=%b fe=%b oe=%b pe=%b, want d_o=%h v=%b fe=%b oe=%b pe=%b",
               name, act.d, act.v, act.fe, act.oe, act.pe,
               exp.d, exp.v, exp.fe, exp.oe, exp.pe);
    end
  endtask

  // Receiver behaviour when a frame finishes.
  function automatic obs_t complete(obs_t m, logic [DS-1:0] w, logic fe, logic pe, bit ack);
    obs_t r;
    r = m;
    if (m.v && !ack) begin
      r.oe = 1'b1;
      r.fe = m.fe | fe;
      r.pe = m.pe | pe;
    end else begin
      r.d  = w;
      r.v  = 1'b1;
      r.fe = fe;
      r.pe = pe;
      r.oe = 1'b0;
    end
    return r;
  endfunction

  task automatic expect_state(input obs_t nxt);
    if (nxt !== model) exp_q.push_back(nxt);
    model = nxt;
  endtask

  // Monitor: every visible output change consumes one expected entry.
  initial begin
    obs_t prev;
    obs_t cur;
    obs_t e;
    wait (mon_on);
    prev = sample_dut();
    forever begin
      @(negedge clk);
      cur = sample_dut();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: got d_o=%h v=%b fe=%b oe=%b pe=%b, want no change",
                   cur.d, cur.v, cur.fe, cur.oe, cur.pe);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", cur, e);
        end
      end
      prev = cur;
    end
  end

  task automatic hold_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (sample_tick) c++;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DS-1:0] d, input logic stop,
                            input logic pflip, input bit ack_co);
    expect_state(complete(model, d, ~stop, pflip & PAR_EN, ack_co));
    @(negedge clk);
    data_in = 1'b0;
    fork
      begin
        hold_ticks(OS);
        for (int i = 0; i < DS; i++) begin
          data_in = d[i];
          hold_ticks(OS);
        end
`ifdef RX_PARITY_EN
        data_in = (^d) ^ pflip;
        hold_ticks(OS);
`endif
        data_in = stop;
        hold_ticks(OS);
        data_in = 1'b1;
      end
      begin
        if (ack_co) begin
          int n;
          n = 0;
          // Two synchronizer flops plus the edge-detect cycle.
          repeat (3) @(posedge clk);
          while (n < STOP_TARGET) begin
            @(posedge clk);
            if (sample_tick) n++;
          end
          @(negedge clk);
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
        end
      end
    join
  endtask

  task automatic do_ack();
    if (model.v) expect_state(mk(model.d, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic [DS-1:0] rd;
    logic          rstop;
    logic          rpf;
    bit            rco;

    reset   = 1'b1;
    data_in = 1'b1;
    rx_ack  = 1'b0;
    total   = 0;
    bad     = 0;
    mon_on  = 1'b0;
    model   = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", sample_dut(), mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset  = 1'b1;
    mon_on = 1'b1;
    hold_ticks(8);

    // Good frame.
    send_frame(7'h55, 1'b1, 1'b0, 1'b0);
    hold_ticks(4);
    check("good_55", sample_dut(), mk(7'h55, 1'b1, 1'b0, 1'b0, 1'b0));
    do_ack();
    hold_ticks(4);
    check("ack_55", sample_dut(), mk(7'h55, 1'b0, 1'b0, 1'b0, 1'b0));

    // False start: short low pulse.
    data_in = 1'b0;
    hold_ticks(4);
    data_in = 1'b1;
    hold_ticks(24);
    check("false_start", sample_dut(), mk(7'h55, 1'b0, 1'b0, 1'b0, 1'b0));

    // Framing error.
    send_frame(7'h2A, 1'b0, 1'b0, 1'b0);
    hold_ticks(4);
    check("framing_2a", sample_dut(), mk(7'h2A, 1'b1, 1'b1, 1'b0, 1'b0));
    do_ack();
    hold_ticks(4);
    check("framing_ack", sample_dut(), mk(7'h2A, 1'b0, 1'b0, 1'b0, 1'b0));

    // Overrun, then a second pair with an ack coinciding with completion.
    send_frame(7'h11, 1'b1, 1'b0, 1'b0);
    hold_ticks(6);
    send_frame(7'h22, 1'b1, 1'b0, 1'b0);
    hold_ticks(6);
    check("overrun", sample_dut(), mk(7'h11, 1'b1, 1'b0, 1'b1, 1'b0));
    do_ack();
    hold_ticks(4);
    send_frame(7'h11, 1'b1, 1'b0, 1'b0);
    hold_ticks(6);
    send_frame(7'h22, 1'b1, 1'b0, 1'b1);
    hold_ticks(6);
    check("ack_coincide", sample_dut(), mk(7'h22, 1'b1, 1'b0, 1'b0, 1'b0));
    do_ack();
    hold_ticks(4);

`ifdef RX_PARITY_EN
    // 0x03 has even data parity, so parity bit 1 is a mismatch.
    send_frame(7'h03, 1'b1, 1'b1, 1'b0);
    hold_ticks(4);
    check("parity_bad", sample_dut(), mk(7'h03, 1'b1, 1'b0, 1'b0, 1'b1));
    do_ack();
    hold_ticks(4);
    send_frame(7'h03, 1'b1, 1'b0, 1'b0);
    hold_ticks(4);
    check("parity_good", sample_dut(), mk(7'h03, 1'b1, 1'b0, 1'b0, 1'b0));
    do_ack();
    hold_ticks(4);
`endif

    // Make d_o nonzero, then reset during data bit 3.
    send_frame(7'h66, 1'b1, 1'b0, 1'b0);
    hold_ticks(4);
    rd = 7'h5A;
    data_in = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      data_in = rd[i];
      hold_ticks(OS);
    end
    data_in = rd[3];
    hold_ticks(OS / 2);
    expect_state('0);
    @(posedge clk);
    #2 reset = 1'b0;
    data_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_mid_frame", sample_dut(), mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    hold_ticks(20);
    check("after_reset_idle", sample_dut(), mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(7'h7F, 1'b1, 1'b0, 1'b0);
    hold_ticks(4);
    check("frame_7f", sample_dut(), mk(7'h7F, 1'b1, 1'b0, 1'b0, 1'b0));
    do_ack();
    hold_ticks(4);

    // Randomized frames, errors, acks and ack/completion collisions.
    for (int k = 0; k < 30; k++) begin
      rd    = DS'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rpf   = ($urandom_range(0, 3) == 0);
      rco   = ($urandom_range(0, 3) == 0);
      send_frame(rd, rstop, rpf, rco);
      hold_ticks(int'($urandom_range(4, 12)));
      check("random_state", sample_dut(), model);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        hold_ticks(4);
      end
    end

    hold_ticks(40);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected changes, want 0", exp_q.size());
    end
    check("final_state", sample_dut(), model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx

// File: doc/rx.md
RX -- requirements
Module: rx

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 7, data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample_tick pulses per bit period; it SHALL be even and at least 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be in this domain.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sample_tick, input, 1, one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port data_in, input, 1, serial line (idle high), asynchronous to clk.
REQ-007 SHALL have port rx_ack, input, 1, consumer pulse acknowledging d_o.
REQ-008 SHALL have port d_o, output, DATA_SIZE, last received word.
REQ-009 SHALL have port rx_valid, output, 1, d_o holds unacknowledged data.
REQ-010 SHALL have port framing_err, output, 1, sticky: a stop bit was sampled low.
REQ-011 SHALL have port overrun_err, output, 1, sticky: a frame completed while rx_valid was 1.
REQ-012 SHALL have port parity_err, output, 1, sticky: parity mismatch (macro-dependent, see REQ-030).

Function
REQ-013 SHALL pass data_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, and only those.
REQ-015 SHALL leave IDLE for START when a high-to-low transition of the synchronized line is seen, and SHALL clear the sample counter on that transition.
REQ-016 SHALL, in START, count OVERSAMPLE/2 sample_ticks, then sample the line: if 0, go to DATA; if 1, treat it as a false start and return to IDLE with no flags changed.
REQ-017 SHALL, in DATA, sample one bit every OVERSAMPLE sample_ticks, LSB first, DATA_SIZE bits, using a bit counter of width $clog2(DATA_SIZE+1).
REQ-018 SHALL go from DATA to PARITY when RX_PARITY_EN is defined, and otherwise to STOP.
REQ-019 SHALL sample the stop bit OVERSAMPLE sample_ticks after the last data or parity sample, and then return to IDLE in the same cycle.
REQ-020 SHALL, on the clk after the stop sample, load d_o, set rx_valid, and set framing_err if the stop bit was 0. An errored frame SHALL still be delivered.
REQ-021 SHALL, when a frame completes while rx_valid=1 and rx_ack=0, keep d_o unchanged, discard the new word and set overrun_err.
REQ-022 SHALL clear rx_valid and all three error flags on rx_ack=1 while rx_valid=1; rx_ack while rx_valid=0 SHALL be ignored.
REQ-023 SHALL, when rx_ack and frame completion coincide, load the new word, keep rx_valid=1, leave overrun_err unset, and set only the error flags of the new frame.
REQ-024 SHALL ignore clk cycles without sample_tick in all counting; counters SHALL NOT advance or wrap between ticks.

Reset
REQ-025 SHALL, on reset=0, immediately force state IDLE, counters 0, synchronizer flops 1, d_o 0, rx_valid 0, and all error flags 0.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame with no output; after release, reception SHALL begin only at the next falling edge.

Configuration
REQ-027 SHALL support macro RX_PARITY_EN.
REQ-028 SHALL, with RX_PARITY_EN defined, expect one even-parity bit after the data bits, sampled like a data bit.
REQ-029 SHALL, with RX_PARITY_EN defined, set parity_err together with rx_valid when the XOR of the data bits and the parity bit is 1.
REQ-030 SHALL, without RX_PARITY_EN, contain no PARITY logic and tie parity_err to 0.

Structure
REQ-031 SHALL take the state enum and the default OVERSAMPLE constant from shared package uart_pkg.
REQ-032 SHALL place the output register, rx_valid/ack handshake and sticky flags in sub-module rdr; the FSM, counters and shift register stay in rx.

Verification
REQ-033 SHALL cover a good frame: line sends 0x55 at 16x ticks -> one clk after stop sample, d_o=0x55, rx_valid=1, all flags 0.
REQ-034 SHALL cover a false start: line low for 4 sample_ticks, then high -> state returns to IDLE, rx_valid stays 0.
REQ-035 SHALL cover a framing error: frame 0x2A with stop bit 0 -> d_o=0x2A, rx_valid=1, framing_err=1; rx_ack clears both.
REQ-036 SHALL cover overrun: frames 0x11 then 0x22 with no ack -> d_o=0x11, overrun_err=1; ack in the same cycle as the second completion -> d_o=0x22, overrun_err=0.
REQ-037 SHALL cover reset mid-frame: reset=0 during data bit 3 -> all outputs 0; the next full frame 0x7F is received correctly.
REQ-038 SHALL cover parity (RX_PARITY_EN): frame 0x03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
